// File: rtl/axi_streams_combin_nch_if.sv
// axi_stream_inf: AXI-stream bundle shared by the combiner inputs and output.
// tuser is a single sideband bit; tkeep is one bit per data byte (minimum 1).

interface axi_stream_inf #(
    parameter int DSIZE = 8
);
    localparam int KSIZE = (DSIZE / 8 > 0) ? DSIZE / 8 : 1;

    logic [DSIZE-1:0] tdata;
    logic [KSIZE-1:0] tkeep;
    logic             tuser;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slaver (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/axi_streams_combin_nch.sv
// axi_streams_combin_nch: concatenates the masked input channels, lowest index first,
// into one output frame per accepted trigger, through a one-deep output register.
// Define AXI_STREAMS_COMBIN_NCH_BODY_CUT_EN to cut BODY_CH into segments of at most
// new_body_len beats; otherwise every channel ends on its own tlast.

module axi_streams_combin_nch #(
    parameter int NUM     = 3,
    parameter int DSIZE   = 8,
    parameter int BODY_CH = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              trigger_signal,
    input  logic [NUM-1:0]    ch_mask,
    input  logic [15:0]       new_body_len,
    output logic              trigger_drop,
    output logic              busy,
    axi_stream_inf.slaver     s_inf [NUM],
    axi_stream_inf.master     m00
);
    localparam int KSIZE = (DSIZE / 8 > 0) ? DSIZE / 8 : 1;
    localparam int CW    = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [NUM-1:0] ChOne = NUM'(1);

    typedef enum logic [1:0] {StIdle, StSel, StRun, StFlush} state_e;

    state_e           state_q, state_d;
    logic [NUM-1:0]   mask_q;
    logic [CW-1:0]    cur_q;
    logic             last_ch_q;

    logic [DSIZE-1:0] in_data [NUM];
    logic [KSIZE-1:0] in_keep [NUM];
    logic [NUM-1:0]   in_user, in_valid, in_last, in_ready;

    logic             m_valid_q, m_last_q, m_user_q;
    logic [DSIZE-1:0] m_data_q;
    logic [KSIZE-1:0] m_keep_q;
    logic             trigger_drop_q;

    logic             trig_accept, run_ready, accept, seg_end;
    logic [CW-1:0]    low_idx;
    logic [NUM-1:0]   mask_clr;

    // Flatten the interface array so the active channel can be selected by index.
    for (genvar g = 0; g < NUM; g++) begin : g_ch
        assign in_data[g]      = s_inf[g].tdata;
        assign in_keep[g]      = s_inf[g].tkeep;
        assign in_user[g]      = s_inf[g].tuser;
        assign in_valid[g]     = s_inf[g].tvalid;
        assign in_last[g]      = s_inf[g].tlast;
        assign s_inf[g].tready = in_ready[g];
    end

    assign trig_accept = (state_q == StIdle) && trigger_signal && (|ch_mask);
    assign accept      = run_ready && in_valid[cur_q];

    // Lowest pending channel and the mask with it removed.
    always_comb begin
        low_idx = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = CW'(i);
        end
        mask_clr = mask_q & ~(ChOne << low_idx);
    end

`ifdef AXI_STREAMS_COMBIN_NCH_BODY_CUT_EN
    logic [15:0] len_q, bcnt_q;
    logic        is_body;

    assign is_body = (cur_q == CW'(BODY_CH));
    assign seg_end = in_last[cur_q] || (is_body && (bcnt_q == len_q - 16'd1));

    // Latch the segment length per frame; count accepted body beats, saturating.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            len_q  <= 16'd1;
            bcnt_q <= '0;
        end else if (clk_en) begin
            if (trig_accept) len_q <= (new_body_len == 16'd0) ? 16'd1 : new_body_len;
            if (state_q == StSel) begin
                bcnt_q <= '0;
            end else if (accept && is_body && (bcnt_q != 16'hFFFF)) begin
                bcnt_q <= bcnt_q + 16'd1;
            end
        end
    end
`else
    logic unused_len;

    assign unused_len = ^new_body_len;
    assign seg_end    = in_last[cur_q];
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!rst_n)      state_q <= StIdle;
        else if (clk_en) state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trig_accept) state_d = StSel;
            StSel:   state_d = StRun;
            StRun:   if (accept && seg_end) state_d = last_ch_q ? StFlush : StSel;
            StFlush: if (!m_valid_q || m00.tready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode: only the current channel sees tready, and only when the slice can take a beat.
    always_comb begin
        run_ready = (state_q == StRun) && clk_en && (!m_valid_q || m00.tready);
        in_ready  = run_ready ? (ChOne << cur_q) : '0;
        busy      = (state_q != StIdle);
    end

    // Frame bookkeeping: latched mask, current channel, last-channel flag.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            mask_q    <= '0;
            cur_q     <= '0;
            last_ch_q <= 1'b0;
        end else if (clk_en) begin
            if (trig_accept) begin
                mask_q <= ch_mask;
            end else if (state_q == StSel) begin
                cur_q     <= low_idx;
                mask_q    <= mask_clr;
                last_ch_q <= (mask_clr == '0);
            end
        end
    end

    // Output register slice; tlast marks only the end of the final channel.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
        end else if (clk_en) begin
            if (accept) begin
                m_valid_q <= 1'b1;
                m_last_q  <= seg_end && last_ch_q;
                m_user_q  <= in_user[cur_q];
                m_data_q  <= in_data[cur_q];
                m_keep_q  <= in_keep[cur_q];
            end else if (m00.tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    // Registered one-cycle pulse for a trigger that cannot start a frame.
    always_ff @(posedge clock) begin
        if (!rst_n) trigger_drop_q <= 1'b0;
        else        trigger_drop_q <= clk_en && trigger_signal &&
                                      ((state_q != StIdle) || (ch_mask == '0));
    end

    assign trigger_drop = trigger_drop_q;
    assign m00.tvalid   = m_valid_q;
    assign m00.tlast    = m_last_q;
    assign m00.tuser    = m_user_q;
    assign m00.tdata    = m_data_q;
    assign m00.tkeep    = m_keep_q;
endmodule

// File: tb/tb_axi_streams_combin_nch.sv
// tb_axi_streams_combin_nch: directed and random frames checked against a queue-based
// reference of the frame-building rules. Cut tests follow AXI_STREAMS_COMBIN_NCH_BODY_CUT_EN.

module tb_axi_streams_combin_nch;
`ifdef AXI_STREAMS_COMBIN_NCH_BODY_CUT_EN
    localparam bit CUT = 1'b1;
`else
    localparam bit CUT = 1'b0;
`endif
    localparam int BODY = 1;

    // beat_t: [9] tuser, [8] input tlast, [7:0] tdata; tkeep is driven from tdata[7]
    typedef logic [9:0] beat_t;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        trigger_signal = 1'b0;
    logic [2:0]  ch_mask = '0;
    logic [15:0] new_body_len = '0;
    logic        trigger_drop, busy;
    logic        m_ready = 1'b1;

    logic [7:0]  src_data [3];
    logic [0:0]  src_keep [3];
    logic [2:0]  src_user, src_valid, src_last, src_ready;

    axi_stream_inf #(.DSIZE(8)) s_inf [3] ();
    axi_stream_inf #(.DSIZE(8)) m00 ();

    for (genvar g = 0; g < 3; g++) begin : g_src
        assign s_inf[g].tdata  = src_data[g];
        assign s_inf[g].tkeep  = src_keep[g];
        assign s_inf[g].tuser  = src_user[g];
        assign s_inf[g].tvalid = src_valid[g];
        assign s_inf[g].tlast  = src_last[g];
        assign src_ready[g]    = s_inf[g].tready;
    end
    assign m00.tready = m_ready;

    axi_streams_combin_nch #(.NUM(3), .DSIZE(8), .BODY_CH(BODY)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .clk_en         (clk_en),
        .trigger_signal (trigger_signal),
        .ch_mask        (ch_mask),
        .new_body_len   (new_body_len),
        .trigger_drop   (trigger_drop),
        .busy           (busy),
        .s_inf          (s_inf),
        .m00            (m00)
    );

    always #5 clock = ~clock;

    beat_t       src_q [3][$];
    beat_t       mq [3][$];
    logic [10:0] got[$];
    logic [10:0] exp_q[$];

    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, busy_cyc = 0, drop_cnt = 0, bad_ready = 0;
    int   first_out = -1, last_out = -1;
    logic [2:0] mask_watch = '0;
    bit   rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < 3; i++) begin
            if (src_q[i].size() > 0) begin
                src_valid[i] = 1'b1;
                src_data[i]  = src_q[i][0][7:0];
                src_keep[i]  = src_q[i][0][7];
                src_last[i]  = src_q[i][0][8];
                src_user[i]  = src_q[i][0][9];
            end else begin
                src_valid[i] = 1'b0;
                src_data[i]  = '0;
                src_keep[i]  = '0;
                src_last[i]  = 1'b0;
                src_user[i]  = 1'b0;
            end
        end
    endtask

    task automatic push_pkt(input int ch, input int len);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b[7:0] = 8'($urandom);
            b[9]   = 1'($urandom);
            b[8]   = (j == len - 1);
            src_q[ch].push_back(b);
            mq[ch].push_back(b);
        end
        drive_srcs();
    endtask

    // One clock: observe handshakes at negedge, advance sources after the edge.
    task automatic tick();
        logic [2:0] fire;
        @(negedge clock);
        if (busy) busy_cyc++;
        if (trigger_drop) drop_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (src_ready[i] && !mask_watch[i]) bad_ready++;
            fire[i] = src_valid[i] && src_ready[i];
        end
        if (m00.tvalid && m_ready) begin
            got.push_back({m00.tlast, m00.tkeep, m00.tuser, m00.tdata});
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) if (fire[i]) void'(src_q[i].pop_front());
        drive_srcs();
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Reference: masked channels in ascending order, each up to its tlast (or the body cut).
    task automatic build_expected(input logic [2:0] m, input logic [15:0] len);
        int eff;
        int n;
        beat_t b;
        logic [10:0] t;
        eff = (len == 16'd0) ? 1 : int'(len);
        exp_q.delete();
        for (int ch = 0; ch < 3; ch++) begin
            if (m[ch]) begin
                n = 0;
                while (mq[ch].size() > 0) begin
                    b = mq[ch].pop_front();
                    n++;
                    exp_q.push_back({1'b0, b[7], b[9], b[7:0]});
                    if (b[8] || (CUT && ch == BODY && n == eff)) break;
                end
            end
        end
        if (exp_q.size() > 0) begin
            t = exp_q.pop_back();
            t[10] = 1'b1;
            exp_q.push_back(t);
        end
    endtask

    task automatic run_frame(input logic [2:0] m, input logic [15:0] len, input bit rnd,
                             input int inject);
        int k;
        bit done;
        got.delete();
        build_expected(m, len);
        first_out  = -1;
        last_out   = -1;
        busy_cyc   = 0;
        bad_ready  = 0;
        mask_watch = m;
        rand_ready = rnd;
        ch_mask        = m;
        new_body_len   = len;
        trigger_signal = 1'b1;
        tick();
        trigger_signal = 1'b0;
        check("busy_rise", busy, 1);
        k = 1;
        done = 1'b0;
        while (!done && k < 400) begin
            trigger_signal = (k == inject);
            tick();
            trigger_signal = 1'b0;
            k++;
            if (!busy) done = 1'b1;
        end
        check("frame_done", done, 1);
        check("beat_count", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check($sformatf("beat%0d", i), got[i], exp_q[i]);
        check("stray_ready", bad_ready, 0);
        rand_ready = 1'b0;
        m_ready    = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        logic [2:0] m;
        drive_srcs();

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_tvalid", m00.tvalid, 0);
        check("rst_tlast", m00.tlast, 0);
        check("rst_tdata", m00.tdata, 0);
        check("rst_tkeep", m00.tkeep, 0);
        check("rst_tuser", m00.tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", trigger_drop, 0);
        check("rst_tready", src_ready, 0);
        rst_n = 1'b1;
        tick();

        // All channels, 2/4/1 beats, no backpressure: 11 busy cycles, 2 bubbles
        push_pkt(0, 2);
        push_pkt(1, 4);
        push_pkt(2, 1);
        d0 = drop_cnt;
        run_frame(3'b111, 16'hFFFF, 1'b0, 0);
        check("t1_busy_cycles", busy_cyc, 11);
        check("t1_bubbles", last_out - first_out + 1 - 7, 2);
        check("t1_no_drop", drop_cnt - d0, 0);

        if (CUT) begin
            // 5-beat body cut at 3: 3 beats then the remaining 2
            push_pkt(1, 5);
            run_frame(3'b010, 16'd3, 1'b0, 0);
            check("cut_f1_len", got.size(), 3);
            run_frame(3'b010, 16'd3, 1'b0, 0);
            check("cut_f2_len", got.size(), 2);
            // Length 0 behaves as 1
            push_pkt(1, 3);
            for (int f = 0; f < 3; f++) begin
                run_frame(3'b010, 16'd0, 1'b0, 0);
                check("cut_len0", got.size(), 1);
            end
        end

        // Skipped middle channel never sees tready
        push_pkt(0, 3);
        push_pkt(1, 2);
        push_pkt(2, 2);
        n = src_q[1].size();
        run_frame(3'b101, 16'hFFFF, 1'b0, 0);
        check("skip_ch1_untouched", src_q[1].size(), n);

        // Empty mask: drop pulse, no frame
        mask_watch     = 3'b000;
        bad_ready      = 0;
        d0             = drop_cnt;
        ch_mask        = 3'b000;
        trigger_signal = 1'b1;
        tick();
        trigger_signal = 1'b0;
        tick();
        check("empty_drop", drop_cnt - d0, 1);
        check("empty_busy", busy, 0);
        check("empty_ready", bad_ready, 0);

        // Random frames, random backpressure, mid-frame trigger in every other frame
        for (int r = 0; r < 16; r++) begin
            m = 3'($urandom_range(1, 7));
            for (int ch = 0; ch < 3; ch++) if (m[ch]) push_pkt(ch, $urandom_range(1, 5));
            d0 = drop_cnt;
            run_frame(m, 16'($urandom_range(0, 6)), 1'b1, (r % 2 == 1) ? 2 : 0);
            check("rand_drop", drop_cnt - d0, (r % 2 == 1) ? 1 : 0);
        end

        // Reset during RUN abandons the frame without tlast
        for (int ch = 0; ch < 3; ch++) begin
            src_q[ch].delete();
            mq[ch].delete();
        end
        push_pkt(0, 4);
        push_pkt(1, 4);
        push_pkt(2, 4);
        got.delete();
        mask_watch     = 3'b111;
        ch_mask        = 3'b111;
        new_body_len   = 16'hFFFF;
        trigger_signal = 1'b1;
        tick();
        trigger_signal = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("rr_tvalid", m00.tvalid, 0);
        check("rr_busy", busy, 0);
        check("rr_tready", src_ready, 0);
        rst_n = 1'b1;
        n = 0;
        foreach (got[i]) if (got[i][10]) n++;
        check("rr_no_tlast", n, 0);
        for (int ch = 0; ch < 3; ch++) begin
            src_q[ch].delete();
            mq[ch].delete();
        end
        push_pkt(0, 2);
        push_pkt(1, 1);
        push_pkt(2, 3);
        run_frame(3'b111, 16'hFFFF, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_streams_combin_nch.md
# axi_streams_combin_nch

Frame builder that concatenates up to NUM AXI-stream input channels, in ascending index order, into one output packet per trigger. A per-frame channel mask selects which inputs take part. The body channel can optionally be cut into fixed-length segments. Sits in front of packet senders (header/payload/trailer assembly) and extends the three-channel head/body/end combiner to N channels with a registered output.

## Interface
Parameters:
- NUM, 3: number of input channels (2..16).
- DSIZE, 8: tdata width.
- KSIZE, (DSIZE/8>0)?DSIZE/8:1: tkeep width (localparam).
- BODY_CH, 1: index of the channel subject to length cutting (0..NUM-1).

Ports:
- clock  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- clk_en  in  1  global clock enable; when low, no state, counter or handshake advances.
- trigger_signal  in  1  start one frame (sampled in IDLE only).
- ch_mask  in  NUM  channel enable, latched on accepted trigger.
- new_body_len  in  16  BODY_CH segment length in beats, latched on accepted trigger; 0 treated as 1.
- trigger_drop  out  1  one-cycle pulse: trigger seen while not IDLE, or trigger with empty mask.
- busy  out  1  high from accepted trigger until the last output beat is accepted.
- s_inf[NUM]  axi_stream_inf.slaver  DSIZE  input channels.
- m00  axi_stream_inf.master  DSIZE  combined output.

## Operation
- States: IDLE, SEL, RUN, FLUSH.
- IDLE: on trigger_signal && clk_en && |ch_mask, latch the mask to mask_r and the length to len_r (0 becomes 1), then go to SEL. With an empty mask, pulse trigger_drop and stay in IDLE.
- SEL (1 cycle): cur = lowest set bit of mask_r. Clear that bit. Set last_ch = (mask_r after clearing == 0). Go to RUN.
- RUN: only s_inf[cur].tready can be high; all other inputs see tready = 0.
  - On each accepted beat, forward tdata, tkeep and tuser unchanged into the output register.
  - The channel ends on the accepted beat where seg_end is true.
  - For cur != BODY_CH: seg_end = s_inf[cur].tlast.
  - For cur == BODY_CH (cut enabled): seg_end = tlast || (bcnt == len_r-1).
  - Channel end with last_ch=0: go to SEL.
  - Channel end with last_ch=1: go to FLUSH.
- m00.tlast = seg_end && last_ch on the forwarded beat; it is low on every other beat. Input tlast values are never forwarded directly.
- bcnt (16 bit) counts accepted BODY_CH beats within the current frame. It resets to 0 at SEL, and saturates rather than wrapping.
- When a cut ends the body before its tlast, the remaining body beats stay in the input and are consumed by the next frame that enables BODY_CH.
- FLUSH: wait until the output register has drained (m00.tvalid && m00.tready, or already empty), then go to IDLE.
- A trigger in SEL, RUN or FLUSH is ignored and pulses trigger_drop; it is not queued.
- Reset in any state:
  - State returns to IDLE; mask_r, bcnt and cur are cleared.
  - m00.tvalid is 0 and all s_inf tready are 0.
  - A partially sent frame is abandoned, with no tlast emitted.

## Timing
- Output register slice: latency 1 cycle from input acceptance to m00.tvalid.
- Input ready: s_inf[cur].tready = (state==RUN) && clk_en && (!m00.tvalid || m00.tready). This gives full throughput: one beat per cycle with no bubbles inside a channel.
- 1-cycle bubble per channel switch (SEL).
- Frame overhead: 1 cycle for the IDLE to SEL transition.
- m00 payload is stable while m00.tvalid && !m00.tready.
- Reset values:
  - m00.tvalid=0, m00.tlast=0, tdata/tkeep/tuser=0.
  - busy=0, trigger_drop=0, all s_inf tready=0.
- busy rises the cycle after an accepted trigger and falls the cycle after the last beat leaves.

## Configuration
- AXI_STREAMS_COMBIN_NCH_BODY_CUT_EN.
  - Defined: BODY_CH segments end on tlast or after len_r beats, whichever comes first.
  - Undefined: BODY_CH is treated like every other channel (ends on its tlast only). new_body_len is ignored and the bcnt logic is not built.

## Test plan
- NUM=3, mask=3'b111, ch0 sends 2 beats, ch1 4, ch2 1 (cut disabled) -> 7 output beats, tlast only on beat 7, exactly 2 bubble cycles.
- mask=3'b101 -> ch1 tready is never asserted; output is ch0 then ch2, tlast on the final ch2 beat.
- Cut enabled, new_body_len=3, body input is a 5-beat packet, two triggers with mask=3'b010:
  - Frame 1 is 3 beats with tlast on beat 3.
  - Frame 2 is 2 beats ending on the input tlast.
- new_body_len=0 with cut enabled -> each frame carries exactly 1 body beat.
- Random m00.tready (50%) plus a trigger asserted mid-frame -> no data loss or duplication, one trigger_drop pulse, busy stays high.
- rst_n low for 1 cycle during RUN -> next cycle m00.tvalid=0, busy=0, state IDLE; a following trigger builds a clean frame.
